// File: rtl/tff_count_pkg.sv
// Shared types and step arithmetic for the T flip-flop counter controller.
// Imported by the controller; the step function is also usable by a bench model.
package tff_count_pkg;

  localparam int unsigned MAX_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ACT_INC     = 2'd0,
    ACT_DEC     = 2'd1,
    ACT_TO_ZERO = 2'd2,
    ACT_TO_LIM  = 2'd3
  } step_act_t;

  // Up counting treats any count at or above the limit as terminal.
  function automatic step_act_t step_action(input logic [MAX_W-1:0] cnt,
                                            input logic [MAX_W-1:0] lim,
                                            input logic             up);
    if (up) return (cnt >= lim) ? ACT_TO_ZERO : ACT_INC;
    else    return (cnt == '0)  ? ACT_TO_LIM  : ACT_DEC;
  endfunction

  function automatic logic is_terminal(input step_act_t act);
    return (act == ACT_TO_ZERO) || (act == ACT_TO_LIM);
  endfunction

endpackage

// File: rtl/tff_cell.sv
// One T flip-flop cell with async clear; optional async preset-to-data
// when TFF_COUNT_PRESET_EN is defined.
module tff_cell #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic clr,
`ifdef TFF_COUNT_PRESET_EN
  input  logic pre,
  input  logic pre_bit,
`endif
  input  logic t,
  output logic q
);

  logic r_q;

`ifdef TFF_COUNT_PRESET_EN
  // clr outranks pre so a combined assertion lands on the reset value.
  always_ff @(posedge clk or posedge clr or posedge pre) begin
    if (clr)      r_q <= RST_BIT;
    else if (pre) r_q <= pre_bit;
    else if (t)   r_q <= ~r_q;
  end
`else
  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)    r_q <= RST_BIT;
    else if (t) r_q <= ~r_q;
  end
`endif

  assign q = r_q;

endmodule

// File: rtl/tff_count_ctrl.sv
// Controller for a bank of T flip-flops forming a mod-(limit+1) up/down counter.
// Optional async preset ports are enabled by defining TFF_COUNT_PRESET_EN.
module tff_count_ctrl
  import tff_count_pkg::*;
#(
  parameter int unsigned      WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
`ifdef TFF_COUNT_PRESET_EN
  input  logic             pre,
  input  logic [WIDTH-1:0] pre_val,
`endif
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             cont,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_t           r_state;
  logic             r_dir;
  logic             r_cont;
  logic [WIDTH-1:0] r_lim;
  logic             r_busy;
  logic             r_done;
  logic             r_wrap;

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_toggle;
  logic [MAX_W-1:0] w_cnt_ext;
  logic [MAX_W-1:0] w_lim_ext;
  step_act_t        w_act;
  logic             w_term;
  logic             w_launch;

  assign w_cnt_ext = MAX_W'(w_q);
  assign w_lim_ext = MAX_W'(r_lim);
  assign w_act     = step_action(w_cnt_ext, w_lim_ext, r_dir);
  assign w_term    = is_terminal(w_act);
  assign w_launch  = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start && !stop;

  // Desired next count; the flops only ever see the XOR of this with the present count.
  always_comb begin
    // NOTE: default first so every path assigns w_target and no latch is inferred.
    w_target = w_q;
    case (r_state)
      ST_RUN: begin
        if (!stop && !(w_term && !r_cont)) begin
          case (w_act)
            ACT_INC:     w_target = w_q + WIDTH'(1);
            ACT_DEC:     w_target = w_q - WIDTH'(1);
            ACT_TO_ZERO: w_target = '0;
            ACT_TO_LIM:  w_target = r_lim;
            default:     w_target = w_q;
          endcase
        end
      end
      default: begin
        if (w_launch) w_target = dir ? '0 : limit;
      end
    endcase
  end

  assign w_toggle = w_q ^ w_target;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= ST_IDLE;
      r_dir   <= 1'b0;
      r_cont  <= 1'b0;
      r_lim   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_wrap <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_launch) begin
            r_state <= ST_RUN;
            r_dir   <= dir;
            r_cont  <= cont;
            r_lim   <= limit;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (stop) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_term && r_cont) begin
            r_wrap <= 1'b1;
          end else if (w_term) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    tff_cell #(
      .RST_BIT (RST_VAL[gi])
    ) u_cell (
      .clk     (clk),
      .clr     (clr),
`ifdef TFF_COUNT_PRESET_EN
      .pre     (pre),
      .pre_bit (pre_val[gi]),
`endif
      .t       (w_toggle[gi]),
      .q       (w_q[gi])
    );
  end

  assign count = w_q;
  assign busy  = r_busy;
  assign done  = r_done;
  assign wrap  = r_wrap;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Directed self-checking bench for tff_count_ctrl (WIDTH=4, RST_VAL=0).
// Preset scenarios are compiled in when TFF_COUNT_PRESET_EN is defined.
module tb_tff_count_ctrl;

  localparam int W = 4;

  logic         clk;
  logic         clr;
  logic         start;
  logic         stop;
  logic         dir;
  logic         cont;
  logic [W-1:0] limit;
  logic [W-1:0] count;
  logic         busy;
  logic         done;
  logic         wrap;
`ifdef TFF_COUNT_PRESET_EN
  logic         pre;
  logic [W-1:0] pre_val;
`endif

  int n_checks = 0;
  int n_errors = 0;

  tff_count_ctrl #(
    .WIDTH   (W),
    .RST_VAL (4'd0)
  ) dut (
    .clk     (clk),
    .clr     (clr),
`ifdef TFF_COUNT_PRESET_EN
    .pre     (pre),
    .pre_val (pre_val),
`endif
    .start   (start),
    .stop    (stop),
    .dir     (dir),
    .cont    (cont),
    .limit   (limit),
    .count   (count),
    .busy    (busy),
    .done    (done),
    .wrap    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] e_cnt,
                       input logic e_busy, input logic e_done, input logic e_wrap);
    logic [W+2:0] obs;
    logic [W+2:0] exp;
    obs = {count, busy, done, wrap};
    exp = {e_cnt, e_busy, e_done, e_wrap};
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed count=%0d busy=%b done=%b wrap=%b, expected count=%0d busy=%b done=%b wrap=%b",
             tag, count, busy, done, wrap, e_cnt, e_busy, e_done, e_wrap);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0; cont = 1'b0; limit = '0;
`ifdef TFF_COUNT_PRESET_EN
    pre = 1'b0; pre_val = '0;
`endif
    #3;
    check("reset_active", 4'd0, 1'b0, 1'b0, 1'b0);
    #7;
    clr = 1'b0;
    tick();
    check("reset_released_idle", 4'd0, 1'b0, 1'b0, 1'b0);

    // Single-pass up count to 5.
    dir = 1'b1; cont = 1'b0; limit = 4'd5; start = 1'b1;
    tick();
    check("up5_load", 4'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("up5_step%0d", i), W'(i), 1'b1, 1'b0, 1'b0);
    end
    tick();
    check("up5_done", 4'd5, 1'b0, 1'b1, 1'b0);
    tick();
    check("up5_idle_hold", 4'd5, 1'b0, 1'b0, 1'b0);

    // Continuous down count, limit 3; inputs changed mid-run must be ignored.
    dir = 1'b0; cont = 1'b1; limit = 4'd3; start = 1'b1;
    tick();
    check("dn3_load", 4'd3, 1'b1, 1'b0, 1'b0);
    start = 1'b0; dir = 1'b1; limit = 4'd9; cont = 1'b0;
    tick(); check("dn3_2", 4'd2, 1'b1, 1'b0, 1'b0);
    tick(); check("dn3_1", 4'd1, 1'b1, 1'b0, 1'b0);
    tick(); check("dn3_0", 4'd0, 1'b1, 1'b0, 1'b0);
    tick(); check("dn3_wrap_a", 4'd3, 1'b1, 1'b0, 1'b1);
    tick(); check("dn3_2b", 4'd2, 1'b1, 1'b0, 1'b0);
    tick(); check("dn3_1b", 4'd1, 1'b1, 1'b0, 1'b0);
    tick(); check("dn3_0b", 4'd0, 1'b1, 1'b0, 1'b0);
    tick(); check("dn3_wrap_b", 4'd3, 1'b1, 1'b0, 1'b1);
    stop = 1'b1;
    tick(); check("dn3_stop", 4'd3, 1'b0, 1'b0, 1'b0);
    stop = 1'b0;

    // Continuous up, limit 15: full-range wrap, then stop at 7.
    dir = 1'b1; cont = 1'b1; limit = 4'd15; start = 1'b1;
    tick(); check("up15_load", 4'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    for (int i = 1; i <= 15; i++) tick();
    check("up15_at15", 4'd15, 1'b1, 1'b0, 1'b0);
    tick(); check("up15_wrap", 4'd0, 1'b1, 1'b0, 1'b1);
    for (int i = 1; i <= 7; i++) tick();
    check("up15_at7", 4'd7, 1'b1, 1'b0, 1'b0);
    stop = 1'b1;
    tick(); check("up15_stop", 4'd7, 1'b0, 1'b0, 1'b0);
    tick(); check("up15_stop_hold", 4'd7, 1'b0, 1'b0, 1'b0);

    // start and stop together in IDLE: no run.
    start = 1'b1;
    tick(); check("start_stop_idle", 4'd7, 1'b0, 1'b0, 1'b0);
    stop = 1'b0;

    // start held through DONE: back-to-back run.
    dir = 1'b1; cont = 1'b0; limit = 4'd2;
    tick(); check("b2b_load", 4'd0, 1'b1, 1'b0, 1'b0);
    tick(); check("b2b_1", 4'd1, 1'b1, 1'b0, 1'b0);
    tick(); check("b2b_2", 4'd2, 1'b1, 1'b0, 1'b0);
    tick(); check("b2b_done", 4'd2, 1'b0, 1'b1, 1'b0);
    tick(); check("b2b_restart", 4'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    tick(); check("b2b_r1", 4'd1, 1'b1, 1'b0, 1'b0);
    tick(); check("b2b_r2", 4'd2, 1'b1, 1'b0, 1'b0);
    tick(); check("b2b_rdone", 4'd2, 1'b0, 1'b1, 1'b0);
    tick(); check("b2b_idle", 4'd2, 1'b0, 1'b0, 1'b0);

    // limit 0, single pass: done one cycle after start.
    dir = 1'b1; cont = 1'b0; limit = 4'd0; start = 1'b1;
    tick(); check("lim0_load", 4'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    tick(); check("lim0_done", 4'd0, 1'b0, 1'b1, 1'b0);
    tick(); check("lim0_idle", 4'd0, 1'b0, 1'b0, 1'b0);

    // limit 0, continuous down: wrap every RUN cycle.
    dir = 1'b0; cont = 1'b1; limit = 4'd0; start = 1'b1;
    tick(); check("lim0c_load", 4'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    tick(); check("lim0c_wrap_a", 4'd0, 1'b1, 1'b0, 1'b1);
    tick(); check("lim0c_wrap_b", 4'd0, 1'b1, 1'b0, 1'b1);
    stop = 1'b1;
    tick(); check("lim0c_stop", 4'd0, 1'b0, 1'b0, 1'b0);
    stop = 1'b0;

    // Single-pass down, limit 2.
    dir = 1'b0; cont = 1'b0; limit = 4'd2; start = 1'b1;
    tick(); check("dn2_load", 4'd2, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    tick(); check("dn2_1", 4'd1, 1'b1, 1'b0, 1'b0);
    tick(); check("dn2_0", 4'd0, 1'b1, 1'b0, 1'b0);
    tick(); check("dn2_done", 4'd0, 1'b0, 1'b1, 1'b0);
    tick(); check("dn2_idle", 4'd0, 1'b0, 1'b0, 1'b0);

    // Async clear mid-run.
    dir = 1'b1; cont = 1'b1; limit = 4'd9; start = 1'b1;
    tick(); check("clr_run_load", 4'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    tick(); tick(); tick();
    check("clr_run_at3", 4'd3, 1'b1, 1'b0, 1'b0);
    #2 clr = 1'b1;
    #1 check("clr_async", 4'd0, 1'b0, 1'b0, 1'b0);
    clr = 1'b0;
    tick(); check("clr_after_idle", 4'd0, 1'b0, 1'b0, 1'b0);

`ifdef TFF_COUNT_PRESET_EN
    // Async preset during an up run, limit 12.
    dir = 1'b1; cont = 1'b0; limit = 4'd12; start = 1'b1;
    tick(); check("pre_load", 4'd0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    tick(); check("pre_1", 4'd1, 1'b1, 1'b0, 1'b0);
    #2 pre_val = 4'd9; pre = 1'b1;
    #1 check("pre_async", 4'd9, 1'b1, 1'b0, 1'b0);
    tick(); check("pre_held", 4'd9, 1'b1, 1'b0, 1'b0);
    pre = 1'b0;
    tick(); check("pre_10", 4'd10, 1'b1, 1'b0, 1'b0);
    tick(); check("pre_11", 4'd11, 1'b1, 1'b0, 1'b0);
    tick(); check("pre_12", 4'd12, 1'b1, 1'b0, 1'b0);
    tick(); check("pre_done", 4'd12, 1'b0, 1'b1, 1'b0);
    #2 pre = 1'b1; clr = 1'b1;
    #1 check("clr_beats_pre", 4'd0, 1'b0, 1'b0, 1'b0);
    clr = 1'b0; pre = 1'b0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
